// File: rtl/stream_dispatch_pkg.sv
// Shared types and header field layout for the stream data dispatcher.
package stream_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DROP   = 2'd2,
    KICK   = 2'd3
  } dispatch_state_e;

  localparam int LEN_LSB = 0;
  localparam int ID_LSB  = 32;
  localparam int ID_W    = 32;

endpackage

// File: rtl/rr_core_arbiter.sv
// Combinational round-robin pick: first requesting core at or above ptr, wrapping mod CORES.
module rr_core_arbiter #(
  parameter int CORES = 4,
  localparam int PTR_W = $clog2(CORES)
) (
  input  logic [CORES-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_grant
);

  int               idx;
  logic [PTR_W-1:0] idx_w;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < CORES; i++) begin
      idx   = (int'(ptr) + i) % CORES;
      idx_w = PTR_W'(idx);
      if (!any_grant && req[idx_w]) begin
        grant     = idx_w;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_data_dispatcher.sv
// Parses FIFO packet headers, forwards packets to a round-robin core, drops malformed ones, kicks the loader.
// Optional statistics counters are enabled with `define STREAM_DATA_DISPATCHER_STATS_EN.
module stream_data_dispatcher
  import stream_dispatch_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int DATA_W     = 512,
  parameter int LEN_W      = 32,
  parameter int USEDW_W    = 11,
  parameter int MAX_LEN    = 1024,
  parameter int ADDR_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     recv_fifo_rdreq,
  input  logic [DATA_W-1:0]        recv_fifo_q,
  input  logic [USEDW_W-1:0]       recv_fifo_rdusedw,
  input  logic                     recv_fifo_valid,
  input  logic [CORES-1:0]         core_ready,
  input  logic                     target_snk_ready,
  output logic [$clog2(CORES)-1:0] target_core,
  output logic                     target_core_valid,
  output logic                     target_snk_sop,
  output logic                     target_snk_eop,
  output logic                     target_snk_valid,
  output logic [DATA_W-1:0]        target_snk_data,
  input  logic                     loader_busy,
  output logic                     loader_kick,
  output logic [63:0]              loader_memory_base_addr,
  output logic                     drop_pulse
`ifdef STREAM_DATA_DISPATCHER_STATS_EN
  ,
  output logic [31:0]              stat_pkt_count,
  output logic [31:0]              stat_drop_count,
  output logic [31:0]              stat_beat_count
`endif
);

  localparam int PTR_W = $clog2(CORES);

  dispatch_state_e  state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W-1:0] used_ext;
  logic [ID_W-1:0]  hdr_id;
  logic [ID_W-1:0]  data_id_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] rr_next;
  logic             any_grant;
  logic             adv;
  logic             snk_accept;
  logic             hdr_fits;
  logic             hdr_empty;
  logic             hdr_oversize;
  logic             rd_c;
  logic             take_hdr;
  logic             drop_start;
  logic             drop_done;
  logic             load_beat;
  logic             load_sop;
  logic             load_eop;
  logic             kick_go;
  logic             cnt_dec;

  assign hdr_len      = recv_fifo_q[LEN_LSB +: LEN_W];
  assign hdr_id       = recv_fifo_q[ID_LSB +: ID_W];
  assign used_ext     = LEN_W'(recv_fifo_rdusedw);
  assign hdr_empty    = (hdr_len == '0);
  assign hdr_oversize = (hdr_len > LEN_W'(MAX_LEN));

  // Single output slot: it may load whenever it is empty or being drained this cycle.
  assign adv        = !target_snk_valid || target_snk_ready;
  assign snk_accept = target_snk_valid && target_snk_ready;
  assign hdr_fits   = (used_ext >= hdr_len) && any_grant && adv;
  assign rr_next    = (grant == PTR_W'(CORES - 1)) ? '0 : grant + PTR_W'(1);

  assign recv_fifo_rdreq = reset_n && rd_c;

  rr_core_arbiter #(.CORES(CORES)) u_arb (
    .req       (core_ready),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (recv_fifo_valid && !hdr_empty) begin
          if (hdr_oversize)  state_d = DROP;
          else if (hdr_fits) state_d = (hdr_len == LEN_W'(1)) ? KICK : STREAM;
        end
      end
      STREAM: if (adv && recv_fifo_valid && cnt_q == LEN_W'(1)) state_d = KICK;
      DROP:   if (recv_fifo_valid && cnt_q == LEN_W'(1)) state_d = IDLE;
      KICK:   if (adv && !loader_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_c       = 1'b0;
    take_hdr   = 1'b0;
    drop_start = 1'b0;
    drop_done  = 1'b0;
    load_beat  = 1'b0;
    load_sop   = 1'b0;
    load_eop   = 1'b0;
    kick_go    = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (recv_fifo_valid) begin
          if (hdr_empty) begin
            rd_c      = 1'b1;
            drop_done = 1'b1;
          end else if (hdr_oversize) begin
            rd_c       = 1'b1;
            drop_start = 1'b1;
          end else if (hdr_fits) begin
            rd_c      = 1'b1;
            take_hdr  = 1'b1;
            load_beat = 1'b1;
            load_sop  = 1'b1;
            load_eop  = (hdr_len == LEN_W'(1));
          end
        end
      end
      STREAM: begin
        if (adv && recv_fifo_valid) begin
          rd_c      = 1'b1;
          load_beat = 1'b1;
          load_eop  = (cnt_q == LEN_W'(1));
          cnt_dec   = 1'b1;
        end
      end
      DROP: begin
        if (recv_fifo_valid) begin
          rd_c      = 1'b1;
          drop_done = (cnt_q == LEN_W'(1));
          cnt_dec   = 1'b1;
        end
      end
      KICK:    kick_go = adv && !loader_busy;
      default: ;
    endcase
  end

  // cnt holds the words still to come after the header; it is nonzero whenever it is decremented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q                   <= '0;
      rr_ptr_q                <= '0;
      data_id_q               <= '0;
      target_core             <= '0;
      target_core_valid       <= 1'b0;
      target_snk_valid        <= 1'b0;
      target_snk_sop          <= 1'b0;
      target_snk_eop          <= 1'b0;
      target_snk_data         <= '0;
      loader_kick             <= 1'b0;
      loader_memory_base_addr <= '0;
      drop_pulse              <= 1'b0;
    end else begin
      if (take_hdr || drop_start) cnt_q <= hdr_len - LEN_W'(1);
      else if (cnt_dec)           cnt_q <= cnt_q - LEN_W'(1);
      if (take_hdr) begin
        target_core <= grant;
        rr_ptr_q    <= rr_next;
        data_id_q   <= hdr_id;
      end
      if (adv) begin
        target_snk_valid <= load_beat;
        target_snk_sop   <= load_sop;
        target_snk_eop   <= load_eop;
      end
      if (load_beat) target_snk_data <= recv_fifo_q;
      if (take_hdr)        target_core_valid <= 1'b1;
      else if (snk_accept) target_core_valid <= 1'b0;
      loader_kick <= kick_go;
      if (kick_go) loader_memory_base_addr <= 64'(data_id_q) << ADDR_SHIFT;
      drop_pulse <= drop_done;
    end
  end

`ifdef STREAM_DATA_DISPATCHER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pkt_count  <= '0;
      stat_drop_count <= '0;
      stat_beat_count <= '0;
    end else begin
      if (kick_go)    stat_pkt_count  <= sat_inc(stat_pkt_count);
      if (drop_done)  stat_drop_count <= sat_inc(stat_drop_count);
      if (snk_accept) stat_beat_count <= sat_inc(stat_beat_count);
    end
  end
`endif

endmodule

// File: tb/tb_stream_data_dispatcher.sv
// Randomized and directed bench for stream_data_dispatcher against a packet-level reference model.
module tb_stream_data_dispatcher;

  localparam int CORES      = 4;
  localparam int DATA_W     = 512;
  localparam int LEN_W      = 32;
  localparam int USEDW_W    = 11;
  localparam int MAX_LEN    = 1024;
  localparam int ADDR_SHIFT = 15;
  localparam int PTR_W      = $clog2(CORES);

  logic               clk;
  logic               reset_n;
  logic               recv_fifo_rdreq;
  logic [DATA_W-1:0]  recv_fifo_q;
  logic [USEDW_W-1:0] recv_fifo_rdusedw;
  logic               recv_fifo_valid;
  logic [CORES-1:0]   core_ready;
  logic               target_snk_ready;
  logic [PTR_W-1:0]   target_core;
  logic               target_core_valid;
  logic               target_snk_sop;
  logic               target_snk_eop;
  logic               target_snk_valid;
  logic [DATA_W-1:0]  target_snk_data;
  logic               loader_busy;
  logic               loader_kick;
  logic [63:0]        loader_memory_base_addr;
  logic               drop_pulse;

  stream_data_dispatcher #(
    .CORES(CORES), .DATA_W(DATA_W), .LEN_W(LEN_W), .USEDW_W(USEDW_W),
    .MAX_LEN(MAX_LEN), .ADDR_SHIFT(ADDR_SHIFT)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .recv_fifo_rdreq         (recv_fifo_rdreq),
    .recv_fifo_q             (recv_fifo_q),
    .recv_fifo_rdusedw       (recv_fifo_rdusedw),
    .recv_fifo_valid         (recv_fifo_valid),
    .core_ready              (core_ready),
    .target_snk_ready        (target_snk_ready),
    .target_core             (target_core),
    .target_core_valid       (target_core_valid),
    .target_snk_sop          (target_snk_sop),
    .target_snk_eop          (target_snk_eop),
    .target_snk_valid        (target_snk_valid),
    .target_snk_data         (target_snk_data),
    .loader_busy             (loader_busy),
    .loader_kick             (loader_kick),
    .loader_memory_base_addr (loader_memory_base_addr),
    .drop_pulse              (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    int                core;
  } beat_t;

  logic [DATA_W-1:0] fifo[$];
  beat_t             exp_beats[$];
  logic [63:0]       exp_kicks[$];
  int                model_ptr;
  int                drops_exp, drops_seen;
  int                beat_cnt, kick_cnt, rd_cnt, last_core;
  int                n_checks, n_errors;
  int                ready_mode;
  logic              busy_rand;
  logic              rd_seen;
  logic              no_rd_on_stall;
  logic              stalled_prev;
  logic [DATA_W-1:0] prev_data;
  logic              prev_sop, prev_eop;
  logic [3:0]        ready_pat;
  int                pat_idx;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic fifo_refresh();
    recv_fifo_valid   = (fifo.size() > 0);
    recv_fifo_q       = (fifo.size() > 0) ? fifo[0] : '0;
    recv_fifo_rdusedw = USEDW_W'(fifo.size());
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: a well-formed packet goes whole to the first ready core from the RR pointer.
  task automatic send_packet(input int len, input logic [31:0] id);
    logic [DATA_W-1:0] w;
    logic [31:0]       len32;
    beat_t             b;
    int                g;
    int                nwords;
    logic              ok;
    ok     = (len > 0) && (len <= MAX_LEN);
    nwords = (len == 0) ? 1 : len;
    len32  = len;
    g      = -1;
    for (int k = 0; k < CORES; k++)
      if (g < 0 && core_ready[(model_ptr + k) % CORES]) g = (model_ptr + k) % CORES;
    for (int i = 0; i < nwords; i++) begin
      w = rand_word();
      if (i == 0) begin
        w[LEN_W-1:0] = len32;
        w[63:32]     = id;
      end
      fifo.push_back(w);
      if (ok) begin
        b.data = w;
        b.sop  = (i == 0);
        b.eop  = (i == len - 1);
        b.core = g;
        exp_beats.push_back(b);
      end
    end
    if (ok) begin
      exp_kicks.push_back(64'(id) << ADDR_SHIFT);
      model_ptr = (g + 1) % CORES;
    end else begin
      drops_exp++;
    end
    fifo_refresh();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(fifo.size() == 0 && exp_beats.size() == 0 && exp_kicks.size() == 0 &&
             drops_seen == drops_exp) && n < budget) begin
      tick(1);
      n++;
    end
    check_val("drain_timeout", (n >= budget), 0);
    tick(3);
    check_val("drop_count", drops_seen, drops_exp);
  endtask

  task automatic flush_model();
    fifo.delete();
    exp_beats.delete();
    exp_kicks.delete();
    model_ptr = 0;
    drops_exp = drops_seen;
    fifo_refresh();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush_model();
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  // FIFO pops and background ready/busy drive, just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen) begin
        if (fifo.size() > 0) void'(fifo.pop_front());
        rd_seen = 1'b0;
      end
      case (ready_mode)
        1: target_snk_ready = ($urandom_range(0, 3) != 0);
        2: begin
          target_snk_ready = ready_pat[pat_idx];
          pat_idx = (pat_idx + 1) % 4;
        end
        default: ;
      endcase
      if (busy_rand) loader_busy = $urandom_range(0, 1);
      fifo_refresh();
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check_val("rdreq_in_reset", recv_fifo_rdreq, 0);
      rd_seen      = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      rd_seen = recv_fifo_rdreq;
      if (recv_fifo_rdreq) begin
        rd_cnt++;
        check_val("rdreq_without_valid", recv_fifo_valid, 1);
      end
      if (stalled_prev) begin
        check_val("hold_valid", target_snk_valid, 1);
        check_val("hold_data", target_snk_data, prev_data);
        check_val("hold_sop", target_snk_sop, prev_sop);
        check_val("hold_eop", target_snk_eop, prev_eop);
      end
      if (no_rd_on_stall && target_snk_valid && !target_snk_ready)
        check_val("rdreq_while_stalled", recv_fifo_rdreq, 0);
      if (target_snk_valid && target_snk_ready) begin
        beat_cnt++;
        if (exp_beats.size() == 0) begin
          check_val("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          check_val("beat_data", target_snk_data, b.data);
          check_val("beat_sop", target_snk_sop, b.sop);
          check_val("beat_eop", target_snk_eop, b.eop);
          check_val("beat_core", target_core, b.core);
          check_val("core_valid", target_core_valid, b.sop);
          if (b.sop) last_core = target_core;
        end
      end
      stalled_prev = target_snk_valid && !target_snk_ready;
      prev_data    = target_snk_data;
      prev_sop     = target_snk_sop;
      prev_eop     = target_snk_eop;
      if (loader_kick) begin
        kick_cnt++;
        if (exp_kicks.size() == 0) check_val("unexpected_kick", 1, 0);
        else check_val("kick_addr", loader_memory_base_addr, exp_kicks.pop_front());
      end
      if (drop_pulse) drops_seen++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, k0, r0, d0, n;
    logic [CORES-1:0] cr;
    reset_n = 1'b0; core_ready = '0; target_snk_ready = 1'b1; loader_busy = 1'b0;
    ready_mode = 0; busy_rand = 1'b0; rd_seen = 1'b0; no_rd_on_stall = 1'b0;
    stalled_prev = 1'b0; prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0;
    ready_pat = 4'b1001; pat_idx = 0; model_ptr = 0; drops_exp = 0; drops_seen = 0;
    beat_cnt = 0; kick_cnt = 0; rd_cnt = 0; last_core = 0; n_checks = 0; n_errors = 0;
    fifo_refresh();
    tick(4);
    reset_n = 1'b1;
    tick(1);
    check_val("rst_valid", target_snk_valid, 0);
    check_val("rst_core_valid", target_core_valid, 0);
    check_val("rst_kick", loader_kick, 0);
    check_val("rst_addr", loader_memory_base_addr, 0);
    check_val("rst_drop", drop_pulse, 0);
    check_val("rst_rdreq", recv_fifo_rdreq, 0);

    // Test 1: len=4, id=3 to core 0.
    core_ready = 4'b0001;
    b0 = beat_cnt; k0 = kick_cnt;
    send_packet(4, 32'd3);
    wait_idle(200);
    check_val("t1_beats", beat_cnt - b0, 4);
    check_val("t1_kicks", kick_cnt - k0, 1);
    check_val("t1_addr", loader_memory_base_addr, 64'h18000);
    check_val("t1_core", last_core, 0);

    // Test 2: two len=2 packets, all cores ready, from a fresh RR pointer.
    do_reset();
    core_ready = 4'b1111;
    send_packet(2, 32'h10);
    send_packet(2, 32'h11);
    wait_idle(200);
    check_val("t2_second_core", last_core, 1);
    send_packet(1, 32'h12);
    wait_idle(200);
    check_val("t2_ptr_after_two", last_core, 2);

    // Test 3: backpressure pattern 1,0,0,1.
    b0 = beat_cnt; r0 = rd_cnt;
    ready_mode = 2; pat_idx = 0; no_rd_on_stall = 1'b1;
    send_packet(3, 32'h20);
    wait_idle(200);
    ready_mode = 0; no_rd_on_stall = 1'b0; target_snk_ready = 1'b1;
    check_val("t3_beats", beat_cnt - b0, 3);
    check_val("t3_rdreq", rd_cnt - r0, 3);

    // Test 4: oversize drop, then len=1, then a MAX_LEN packet.
    core_ready = 4'b0010;
    b0 = beat_cnt; k0 = kick_cnt; r0 = rd_cnt; d0 = drops_seen;
    send_packet(MAX_LEN + 1, 32'h30);
    send_packet(1, 32'h31);
    wait_idle(3000);
    check_val("t4_drops", drops_seen - d0, 1);
    check_val("t4_kicks", kick_cnt - k0, 1);
    check_val("t4_beats", beat_cnt - b0, 1);
    check_val("t4_rdreq", rd_cnt - r0, MAX_LEN + 2);
    b0 = beat_cnt;
    send_packet(MAX_LEN, 32'h32);
    wait_idle(3000);
    check_val("t4_maxlen_beats", beat_cnt - b0, MAX_LEN);

    // Test 5: len=0 header, then len=1 with loader_busy held high.
    b0 = beat_cnt; r0 = rd_cnt; d0 = drops_seen;
    send_packet(0, 32'h40);
    wait_idle(200);
    check_val("t5_len0_rdreq", rd_cnt - r0, 1);
    check_val("t5_len0_beats", beat_cnt - b0, 0);
    check_val("t5_len0_drop", drops_seen - d0, 1);
    loader_busy = 1'b1;
    k0 = kick_cnt;
    send_packet(1, 32'h41);
    n = 0;
    while (exp_beats.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check_val("t5_beat_timeout", (n >= 200), 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_val("t5_kick_while_busy", loader_kick, 0);
    end
    loader_busy = 1'b0;
    tick(1);
    check_val("t5_kick_after_busy", loader_kick, 1);
    wait_idle(200);
    check_val("t5_kicks", kick_cnt - k0, 1);

    // Test 6: reset in the middle of a packet.
    core_ready = 4'b1111;
    b0 = beat_cnt;
    send_packet(8, 32'h50);
    n = 0;
    while (beat_cnt - b0 < 3 && n < 200) begin
      tick(1);
      n++;
    end
    check_val("t6_beat_timeout", (n >= 200), 0);
    reset_n = 1'b0;
    #1;
    check_val("t6_rdreq", recv_fifo_rdreq, 0);
    check_val("t6_valid", target_snk_valid, 0);
    check_val("t6_sop", target_snk_sop, 0);
    check_val("t6_data", target_snk_data, 0);
    check_val("t6_core", target_core, 0);
    check_val("t6_core_valid", target_core_valid, 0);
    check_val("t6_addr", loader_memory_base_addr, 0);
    flush_model();
    tick(2);
    reset_n = 1'b1;
    tick(1);
    core_ready = 4'b0100;
    b0 = beat_cnt; k0 = kick_cnt;
    send_packet(3, 32'h51);
    wait_idle(200);
    check_val("t6_after_beats", beat_cnt - b0, 3);
    check_val("t6_after_kicks", kick_cnt - k0, 1);
    check_val("t6_after_core", last_core, 2);

    // Randomized batches with random backpressure and loader busy.
    ready_mode = 1;
    busy_rand  = 1'b1;
    for (int t = 0; t < 40; t++) begin
      cr = CORES'($urandom_range(1, (1 << CORES) - 1));
      core_ready = cr;
      for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
        if ($urandom_range(0, 9) == 0) send_packet(0, $urandom);
        else send_packet(int'($urandom_range(1, 7)), $urandom);
      end
      wait_idle(2000);
    end
    busy_rand = 1'b0; loader_busy = 1'b0;
    ready_mode = 0; target_snk_ready = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
